// File: rtl/des_key_pkg.sv
// Shared tables, types and rotation helpers for the DES key scheduler.
package des_key_pkg;
  localparam int ROUNDS = 16;

  typedef logic [27:0] half_key_t;
  typedef logic [47:0] round_key_t;
  typedef enum logic [0:0] {S_IDLE, S_RUN} state_e;

  // Table entries are 1-based DES bit numbers, bit 1 = MSB.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32};

  localparam int SHIFT_TABLE [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic int shift_amt(input int r);
    return (r >= 1 && r <= ROUNDS) ? SHIFT_TABLE[r] : 2;
  endfunction

  function automatic half_key_t rol28(input half_key_t x, input int n);
    return (n == 1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic half_key_t ror28(input half_key_t x, input int n);
    return (n == 1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction
endpackage

// File: rtl/permutationChoice2.sv
// PC-2: selects the 48-bit round key from a 56-bit C/D pair.
module permutationChoice2
  import des_key_pkg::*;
(
  input  half_key_t  c_i,
  input  half_key_t  d_i,
  output round_key_t k_o
);
  logic [55:0] cd;

  assign cd = {c_i, d_i};

  always_comb begin
    k_o = '0;
    for (int i = 0; i < 48; i++) k_o[47-i] = cd[56-PC2[i]];
  end
endmodule

// File: rtl/permuted_choice1.sv
// PC-1: drops the parity bits of a 64-bit key and splits the rest into C0/D0.
module permuted_choice1
  import des_key_pkg::*;
(
  input  logic [63:0] key_i,
  output half_key_t   c_o,
  output half_key_t   d_o
);
  logic [55:0] cd;

  always_comb begin
    cd = '0;
    for (int i = 0; i < 56; i++) cd[55-i] = key_i[64-PC1[i]];
  end

  assign c_o = cd[55:28];
  assign d_o = cd[27:0];
endmodule

// File: rtl/des_key_scheduler.sv
// Sequential DES key schedule: takes one key, streams 16 PC-2 round keys over valid/ready.
module des_key_scheduler
  import des_key_pkg::*;
#(
  parameter bit PARITY_CHECK = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  output logic        key_err,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [47:0] rk_out,
  output logic [3:0]  rk_round,
  output logic        rk_last
);
  localparam logic [3:0] LAST = 4'(ROUNDS - 1);

  state_e     state_q;
  half_key_t  c_q, d_q, c_d, d_d, c0, d0;
  logic [3:0] cnt_q, cnt_d, rk_round_q;
  logic       dec_q, rk_valid_q, rk_last_q, key_err_q;
  round_key_t rk_out_q, rk_next;
  logic       parity_ok, accept, load, hs, adv, done;

  permuted_choice1 u_pc1 (.key_i(key_in), .c_o(c0), .d_o(d0));

  always_comb begin
    parity_ok = 1'b1;
    for (int b = 0; b < 8; b++) parity_ok &= ^key_in[8*b +: 8];
  end

  assign accept = (state_q == S_IDLE) && key_valid;
  assign load   = accept && (parity_ok || !PARITY_CHECK);
  assign hs     = rk_valid_q && rk_ready;
  assign adv    = (state_q == S_RUN) && hs && (cnt_q != LAST);
  assign done   = (state_q == S_RUN) && hs && (cnt_q == LAST);

  // Next C/D feeds PC-2 directly so the round key register loads in the same cycle.
  always_comb begin
    c_d   = c_q;
    d_d   = d_q;
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
      c_d   = decrypt ? c0 : rol28(c0, shift_amt(1));
      d_d   = decrypt ? d0 : rol28(d0, shift_amt(1));
    end else if (adv) begin
      cnt_d = cnt_q + 4'd1;
      if (dec_q) begin
        c_d = ror28(c_q, shift_amt(16 - int'(cnt_q)));
        d_d = ror28(d_q, shift_amt(16 - int'(cnt_q)));
      end else begin
        c_d = rol28(c_q, shift_amt(int'(cnt_q) + 2));
        d_d = rol28(d_q, shift_amt(int'(cnt_q) + 2));
      end
    end
  end

  permutationChoice2 u_pc2 (.c_i(c_d), .d_i(d_d), .k_o(rk_next));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      c_q        <= '0;
      d_q        <= '0;
      cnt_q      <= '0;
      dec_q      <= 1'b0;
      rk_out_q   <= '0;
      rk_round_q <= '0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
      key_err_q  <= 1'b0;
    end else if (flush || done) begin
      state_q    <= S_IDLE;
      c_q        <= '0;
      d_q        <= '0;
      cnt_q      <= '0;
      dec_q      <= 1'b0;
      rk_out_q   <= '0;
      rk_round_q <= '0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
      key_err_q  <= 1'b0;
    end else begin
      key_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load) begin
            state_q    <= S_RUN;
            c_q        <= c_d;
            d_q        <= d_d;
            cnt_q      <= cnt_d;
            dec_q      <= decrypt;
            rk_out_q   <= rk_next;
            rk_round_q <= decrypt ? LAST : 4'd0;
            rk_valid_q <= 1'b1;
            rk_last_q  <= 1'b0;
          end else if (accept) begin
            key_err_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (adv) begin
            c_q        <= c_d;
            d_q        <= d_d;
            cnt_q      <= cnt_d;
            rk_out_q   <= rk_next;
            rk_round_q <= dec_q ? rk_round_q - 4'd1 : rk_round_q + 4'd1;
            rk_last_q  <= (cnt_d == LAST);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign key_ready = (state_q == S_IDLE);
  assign key_err   = key_err_q;
  assign rk_valid  = rk_valid_q;
  assign rk_out    = rk_out_q;
  assign rk_round  = rk_round_q;
  assign rk_last   = rk_last_q;
endmodule

// File: tb/tb_des_key_scheduler.sv
// Bench for des_key_scheduler: two instances (parity ignored / parity checked) on shared stimulus.
module tb_des_key_scheduler;
  logic        clk = 1'b0, rst_n = 1'b1, flush = 1'b0, key_valid = 1'b0, decrypt = 1'b0, rk_ready = 1'b0;
  logic [63:0] key_in = '0;
  logic        key_ready0, key_err0, rk_valid0, rk_last0;
  logic        key_ready1, key_err1, rk_valid1, rk_last1;
  logic [47:0] rk_out0, rk_out1;
  logic [3:0]  rk_round0, rk_round1;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  des_key_scheduler #(.PARITY_CHECK(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .key_valid(key_valid), .key_ready(key_ready0),
    .key_in(key_in), .decrypt(decrypt), .key_err(key_err0), .rk_valid(rk_valid0),
    .rk_ready(rk_ready), .rk_out(rk_out0), .rk_round(rk_round0), .rk_last(rk_last0));

  des_key_scheduler #(.PARITY_CHECK(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .key_valid(key_valid), .key_ready(key_ready1),
    .key_in(key_in), .decrypt(decrypt), .key_err(key_err1), .rk_valid(rk_valid1),
    .rk_ready(rk_ready), .rk_out(rk_out1), .rk_round(rk_round1), .rk_last(rk_last1));

  // Reference tables copied from the DES standard.
  int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                     19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

  logic [47:0] exp_ks [16];
  logic [3:0]  exp_rd [16];
  logic [47:0] got_ks [16];

  typedef struct {
    logic [63:0] key;
    bit          dec;
    int          stall_at, stall_len, pulse_at;
    logic [47:0] first;
    int          mid_idx;
    logic [47:0] mid;
    logic [47:0] last;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Round r key uses C0/D0 rotated left by the running sum of shifts; decrypt is the list reversed.
  task automatic build_model(input logic [63:0] key, input bit dec);
    logic [55:0] cd0, cd;
    logic [55:0] c, d;
    logic [47:0] enc [16];
    int tot;
    cd0 = '0;
    for (int i = 0; i < 56; i++) cd0[55-i] = key[64-PC1_T[i]];
    tot = 0;
    for (int r = 1; r <= 16; r++) begin
      tot += (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
      c = {28'b0, cd0[55:28]};
      d = {28'b0, cd0[27:0]};
      c = ((c << tot) | (c >> (28 - tot))) & 56'hFFFFFFF;
      d = ((d << tot) | (d >> (28 - tot))) & 56'hFFFFFFF;
      cd = {c[27:0], d[27:0]};
      enc[r-1] = '0;
      for (int i = 0; i < 48; i++) enc[r-1][47-i] = cd[56-PC2_T[i]];
    end
    for (int i = 0; i < 16; i++) begin
      exp_ks[i] = dec ? enc[15-i] : enc[i];
      exp_rd[i] = dec ? 4'(15 - i) : 4'(i);
    end
  endtask

  function automatic logic [63:0] odd_par(input logic [63:0] k);
    logic [63:0] r;
    r = k;
    for (int b = 0; b < 8; b++) r[8*b] = ~^r[8*b+7 -: 7];
    return r;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_valid0"}, rk_valid0, 0);  check({tag, "_valid1"}, rk_valid1, 0);
    check({tag, "_ready0"}, key_ready0, 1); check({tag, "_ready1"}, key_ready1, 1);
    check({tag, "_out0"}, rk_out0, 0);      check({tag, "_out1"}, rk_out1, 0);
    check({tag, "_round0"}, rk_round0, 0);  check({tag, "_last0"}, rk_last0, 0);
    check({tag, "_last1"}, rk_last1, 0);    check({tag, "_err1"}, key_err1, 0);
  endtask

  // abort_at >= 0 ends the schedule there by flush (abort_rst=0) or by async reset (abort_rst=1).
  task automatic run_sched(input logic [63:0] key, input bit dec, input int stall_at,
                           input int stall_len, input bit rnd, input int pulse_at,
                           input int abort_at, input bit abort_rst);
    int idx, stalled, cyc;
    bit r;
    build_model(key, dec);
    @(negedge clk);
    check("accept_ready0", key_ready0, 1);
    check("accept_ready1", key_ready1, 1);
    key_in = key; decrypt = dec; key_valid = 1'b1; rk_ready = 1'b0;
    @(negedge clk);
    key_valid = 1'b0; key_in = ~key; decrypt = ~dec;
    idx = 0; stalled = 0; cyc = 0;
    while (idx < 16 && cyc < 400) begin
      cyc++;
      check("rk_valid0", rk_valid0, 1);      check("rk_valid1", rk_valid1, 1);
      check("rk_out0", rk_out0, exp_ks[idx]); check("rk_out1", rk_out1, exp_ks[idx]);
      check("rk_round0", rk_round0, exp_rd[idx]); check("rk_round1", rk_round1, exp_rd[idx]);
      check("rk_last0", rk_last0, (idx == 15)); check("rk_last1", rk_last1, (idx == 15));
      check("busy_ready0", key_ready0, 0);
      got_ks[idx] = rk_out0;
      if (idx == abort_at) begin
        if (abort_rst) begin
          rst_n = 1'b0;
          #1 check_idle("rst_async");
          @(negedge clk);
          check_idle("rst_during");
          rst_n = 1'b1;
          @(negedge clk);
          check_idle("rst_after");
        end else begin
          flush = 1'b1; rk_ready = 1'b1;
          @(negedge clk);
          flush = 1'b0; rk_ready = 1'b0;
          check_idle("flush");
        end
        return;
      end
      r = 1'b1;
      if (idx == stall_at && stalled < stall_len) begin
        r = 1'b0; stalled++;
      end else if (rnd) r = ($urandom_range(0, 3) != 0);
      key_valid = (idx == pulse_at);
      rk_ready = r;
      @(negedge clk);
      key_valid = 1'b0;
      if (r) idx++;
    end
    rk_ready = 1'b0;
    if (idx < 16) check("sched_timeout", idx, 16);
    check_idle("done");
  endtask

  vec_t vt [4];

  initial begin
    vt[0] = '{64'h133457799BBCDFF1, 1'b0, -1, 0, -1, 48'h1B02EFFC7072, 1, 48'h79AED9DBC9E5, 48'hCB3D8B0E17F5};
    vt[1] = '{64'h133457799BBCDFF1, 1'b1, -1, 0, -1, 48'hCB3D8B0E17F5, 14, 48'h79AED9DBC9E5, 48'h1B02EFFC7072};
    vt[2] = '{64'h133457799BBCDFF1, 1'b0, 3, 5, -1, 48'h1B02EFFC7072, 1, 48'h79AED9DBC9E5, 48'hCB3D8B0E17F5};
    vt[3] = '{64'h133457799BBCDFF1, 1'b1, -1, 0, 5, 48'hCB3D8B0E17F5, 14, 48'h79AED9DBC9E5, 48'h1B02EFFC7072};

    #1 rst_n = 1'b0;
    @(negedge clk);
    check_idle("reset");
    check("reset_err0", key_err0, 0);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      run_sched(vt[v].key, vt[v].dec, vt[v].stall_at, vt[v].stall_len, 1'b0, vt[v].pulse_at, -1, 1'b0);
      check("vec_first", got_ks[0], vt[v].first);
      check("vec_mid", got_ks[vt[v].mid_idx], vt[v].mid);
      check("vec_last", got_ks[15], vt[v].last);
    end

    // Flush at round 7, then a fresh key.
    run_sched(64'h133457799BBCDFF1, 1'b0, -1, 0, 1'b0, -1, 7, 1'b0);
    run_sched(64'h133457799BBCDFF1, 1'b0, -1, 0, 1'b0, -1, -1, 1'b0);
    check("flush_fresh_k1", got_ks[0], 48'h1B02EFFC7072);

    // Bad parity: only the checking instance rejects it.
    @(negedge clk);
    key_in = 64'h133457799BBCDFF0; decrypt = 1'b0; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("par_err1", key_err1, 1);     check("par_valid1", rk_valid1, 0);
    check("par_ready1", key_ready1, 1); check("par_err0", key_err0, 0);
    check("par_valid0", rk_valid0, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("par_err1_pulse", key_err1, 0);
    check("par_valid1_after", rk_valid1, 0);
    check("par_valid0_flushed", rk_valid0, 0);
    run_sched(64'h133457799BBCDFF1, 1'b0, -1, 0, 1'b0, -1, -1, 1'b0);

    // Async reset at round 9, then a full schedule.
    run_sched(64'h133457799BBCDFF1, 1'b1, -1, 0, 1'b0, -1, 9, 1'b1);
    run_sched(64'h133457799BBCDFF1, 1'b0, -1, 0, 1'b0, -1, -1, 1'b0);

    for (int n = 0; n < 20; n++) begin
      run_sched(odd_par({$urandom, $urandom}), 1'($urandom_range(0, 1)), -1, 0, 1'b1,
                int'($urandom_range(0, 20)), -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
